// File: rtl/tdm_demux_if.sv
// Bundles the serial beat input and the recovered parallel frame output of tdm_demux.
// The slave modport is the demux side, and the master modport is the link driver and consumer side.
interface tdm_demux_if #(
    parameter int N        = 1,
    parameter int CHANNELS = 4
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [N-1:0]          in_data;
    logic                  in_valid;
    logic                  in_sync;
    logic [CHANNELS*N-1:0] out_data;
    logic                  out_valid;
    logic [SW-1:0]         slot;
    logic                  sync_err;
    logic                  locked;

    modport slave (
        input  in_data, in_valid, in_sync,
        output out_data, out_valid, slot, sync_err, locked
    );

    modport master (
        output in_data, in_valid, in_sync,
        input  out_data, out_valid, slot, sync_err, locked
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: it finds frame alignment from the slot-0 sync flag and gathers one word per beat into a shadow frame.
// Each completed frame is presented in parallel, together with a single-cycle valid pulse.
module tdm_demux #(
    parameter int N        = 1,
    parameter int CHANNELS = 4
) (
    input  logic       clock,
    input  logic       reset,
    tdm_demux_if.slave bus
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t                state_q,     state_d;
    logic [SW-1:0]         slot_q,      slot_d;
    logic [CHANNELS*N-1:0] shadow_q,    shadow_d;
    logic [CHANNELS*N-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  sync_err_q,  sync_err_d;

    logic                  wr_en;
    logic [SW-1:0]         wr_idx;
    logic [CHANNELS*N-1:0] merged;

    // Decide which slot, if any, the current beat lands in, and whether it breaks alignment.
    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = '0;
        sync_err_d = 1'b0;
        state_d    = state_q;
        if (bus.in_valid) begin
            if (bus.in_sync) begin
                wr_en      = 1'b1;
                sync_err_d = (state_q == COLLECT) && (slot_q != '0);
                state_d    = COLLECT;
            end else if (state_q == COLLECT) begin
                if (slot_q == '0) begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = slot_q;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            merged[k*N +: N] = (wr_en && wr_idx == SW'(k)) ? bus.in_data : shadow_q[k*N +: N];
        end
    end

    // A write into the last slot completes the frame. The slot counter then wraps without leaving COLLECT.
    always_comb begin
        shadow_d    = shadow_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (wr_en) begin
            shadow_d = merged;
            if (wr_idx == SW'(CHANNELS - 1)) begin
                out_data_d  = merged;
                out_valid_d = 1'b1;
                slot_d      = '0;
            end else begin
                slot_d = wr_idx + SW'(1);
            end
        end else if (sync_err_d) begin
            slot_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.locked    = (state_q == COLLECT);
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux. A queue-based frame model predicts every output after each clock edge.
// Directed scenarios are followed by randomized traffic that includes sync faults, gaps and resets.
module tb_tdm_demux;
    localparam int N        = 8;
    localparam int CHANNELS = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    tdm_demux_if #(.N(N), .CHANNELS(CHANNELS)) bus ();

    tdm_demux #(.N(N), .CHANNELS(CHANNELS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0]          frameQ[$];
    bit                    mLocked;
    logic [CHANNELS*N-1:0] mOut;
    bit                    mValid;
    bit                    mErr;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out_data"},  64'(bus.out_data),  64'(mOut));
        checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mValid));
        checkOutput({tag, ".slot"},      64'(bus.slot),      64'(frameQ.size()));
        checkOutput({tag, ".sync_err"},  64'(bus.sync_err),  64'(mErr));
        checkOutput({tag, ".locked"},    64'(bus.locked),    64'(mLocked));
    endtask

    function automatic void modelReset();
        frameQ.delete();
        mLocked = 1'b0;
        mOut    = '0;
        mValid  = 1'b0;
        mErr    = 1'b0;
    endfunction

    // A frame is the list of words seen since the last accepted sync. It completes when the list holds CHANNELS words.
    function automatic void modelStep(input bit v, input bit s, input logic [N-1:0] d);
        mValid = 1'b0;
        mErr   = 1'b0;
        if (v) begin
            if (s) begin
                if (mLocked && frameQ.size() != 0) mErr = 1'b1;
                frameQ.delete();
                frameQ.push_back(d);
                mLocked = 1'b1;
            end else if (mLocked) begin
                if (frameQ.size() == 0) begin
                    mErr    = 1'b1;
                    mLocked = 1'b0;
                end else begin
                    frameQ.push_back(d);
                end
            end
            if (frameQ.size() == CHANNELS) begin
                for (int k = 0; k < CHANNELS; k++) mOut[k*N +: N] = frameQ[k];
                mValid = 1'b1;
                frameQ.delete();
            end
        end
    endfunction

    task automatic applyStimulus(input string tag, input bit v, input bit s, input logic [N-1:0] d);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        @(posedge clock);
        modelStep(v, s, d);
        #1;
        checkAll(tag);
    endtask

    task automatic gap(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(tag, 1'b0, 1'($urandom_range(0, 1)), N'($urandom));
    endtask

    task automatic applyReset(input string tag);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int txPos;
        bit v;
        bit s;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        modelReset();
        #12;
        checkAll("reset");
        reset = 1'b0;

        for (int i = 0; i < 4; i++) applyStimulus("frame", 1'b1, i == 0, N'(8'hB0 + i));
        gap("idle", 2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("gapped", 1'b1, i == 0, N'(8'hC0 + i));
            gap("gapped.hold", 3);
        end

        applyStimulus("missing", 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 5; i++) applyStimulus("hunt", 1'b1, 1'b0, N'($urandom));

        applyStimulus("early", 1'b1, 1'b1, 8'h01);
        applyStimulus("early", 1'b1, 1'b0, 8'h01);
        applyStimulus("early.sync", 1'b1, 1'b1, 8'h00);
        applyStimulus("early", 1'b1, 1'b0, 8'h00);
        applyStimulus("early", 1'b1, 1'b0, 8'h01);
        applyStimulus("early.done", 1'b1, 1'b0, 8'h00);
        checkOutput("early.frame", 64'(bus.out_data), 64'h0000_0000_0001_0000);

        applyStimulus("mid", 1'b1, 1'b1, 8'h11);
        applyStimulus("mid", 1'b1, 1'b0, 8'h22);
        applyReset("mid.reset");
        for (int i = 0; i < 4; i++) applyStimulus("postreset", 1'b1, i == 0, N'(8'hA0 + i));
        checkOutput("postreset.frame", 64'(bus.out_data), 64'h0000_0000_A3A2_A1A0);

        // Mostly well-formed traffic, with a sync flag occasionally flipped to provoke both fault kinds.
        txPos = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                applyReset("rand.reset");
                txPos = 0;
            end
            v = ($urandom_range(0, 3) != 0);
            s = (txPos == 0);
            if ($urandom_range(0, 11) == 0) s = !s;
            applyStimulus("rand", v, s, N'($urandom));
            if (v) txPos = (s ? 1 : txPos + 1) % CHANNELS;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receiving end of a serialized multiplexer link. A transmitter interleaves CHANNELS words of N bits onto one lane, one word per beat, and marks slot 0 with a sync flag. This block recovers frame alignment, stores each beat into its channel slot, and presents the complete frame in parallel with a one-cycle valid pulse. It sits after the mux-based serializer datapath and feeds per-channel consumers.

## Interface
- N, 1, width in bits of one channel word.
- CHANNELS, 4, words per frame; legal range 1..256.
- SW, derived as max(1, clog2(CHANNELS)), width of the slot counter; not overridden by the user.

- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  N  serial word for the current beat.
- in_valid  input  1  beat qualifier; in_data and in_sync are ignored when low.
- in_sync  input  1  high on the beat carrying slot 0 of a frame.
- out_data  output  CHANNELS*N  last complete frame; slot k at bits [k*N +: N].
- out_valid  output  1  one-cycle pulse when out_data has just been updated.
- slot  output  SW  index the next accepted beat will be written to.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high in COLLECT, low in HUNT.

## Operation
- Internal shadow register of CHANNELS*N bits collects a frame; out_data changes only on frame completion.
- States: HUNT (no alignment), COLLECT (aligned).
- HUNT: valid beat without sync is dropped, no error. Valid beat with sync is written to slot 0, then slot=1 and state becomes COLLECT. With CHANNELS=1, it completes a frame at once.
- COLLECT, valid beat, slot==0, sync high: write slot 0, slot=1.
- COLLECT, valid beat, slot==0, sync low: drop beat, pulse sync_err, go to HUNT, slot=0.
- COLLECT, valid beat, slot!=0, sync low: write shadow[slot], slot=slot+1.
- COLLECT, valid beat, slot!=0, sync high: early sync. Pulse sync_err, discard the partial frame, write the beat to slot 0, set slot=1 and stay in COLLECT.
- Frame completion happens on a write to slot CHANNELS-1. out_data is loaded with the shadow contents merged with the current beat, out_valid pulses, slot wraps to 0 and the state stays COLLECT.
- in_valid low: no state, slot, shadow or output change. Gaps of any length are allowed between beats.
- Stale shadow bits from a discarded frame are never exposed, because every slot is rewritten before the next completion.
- sync_err and out_valid can never both be high in the same cycle.

## Timing
- Reset (asynchronous, active-high): out_data=0, out_valid=0, sync_err=0, slot=0, locked=0, shadow=0, state=HUNT. Reset asserted mid-frame discards the frame at once. The first beat after reset release is evaluated in HUNT.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the last beat is sampled at edge k. From edge k on, out_data holds the new frame and out_valid=1. At edge k+1, out_valid returns to 0 unless another frame completes then, which is only possible when CHANNELS=1.
- Minimum frame time is CHANNELS consecutive valid cycles. Back-to-back frames give out_valid every CHANNELS cycles.
- sync_err is high for the single cycle after the offending edge.
- slot and locked reflect the state after the most recent edge.

## Test plan
- N=1, CHANNELS=4, reset, then 4 consecutive beats 1,0,1,1 with in_sync on the first -> out_data=4'b1101 and out_valid=1 for exactly one cycle after the 4th edge; locked=1 from the first beat.
- Same frame with in_valid low for 3 cycles between each beat -> identical out_data, single out_valid pulse, slot holds during gaps.
- HUNT: 5 valid beats with in_sync=0 -> out_valid=0, sync_err=0, locked=0, slot=0 throughout.
- Early sync: sync beat 1, beat 1, then a sync beat 0, then beats 0,1,0 -> sync_err pulse on the 3rd beat, no out_valid; the next frame completes with out_data=4'b0100.
- Missing sync: after one good frame, the next beat arrives with in_sync=0 -> sync_err pulse, locked=0, out_data keeps the previous frame.
- Reset mid-frame after 2 beats -> all outputs 0 immediately. Then 1 sync beat and 3 more beats (N=8, values 8'hA0..8'hA3) -> out_data=32'hA3A2A1A0.
